// File: rtl/tempsens_pkg.sv
// Shared types and segment constants for the temperature display sequencer.
package tempsens_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SHOW_H,
    SHOW_T,
    SHOW_O,
    BLANK
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam int unsigned DP_BIT   = 7;

  // Leading-zero suppression: first digit state for a given hundreds/tens pair.
  function automatic state_t first_show(input logic [3:0] hund, input logic [3:0] tens);
    if (hund != 4'd0)      return SHOW_H;
    else if (tens != 4'd0) return SHOW_T;
    else                   return SHOW_O;
  endfunction

endpackage

// File: rtl/tempsens_seg7_dec.sv
// BCD digit to 7-segment decoder (g..a, active-high); non-decimal codes go blank.
module tempsens_seg7_dec
  import tempsens_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tempsens_disp_seq.sv
// Converts a temperature code to BCD by sequential double-dabble and cycles its
// digits on a 7-segment display, with a one-deep last-value-wins pending slot.
module tempsens_disp_seq
  import tempsens_pkg::*;
#(
  parameter int unsigned VAL_W        = 7,
  parameter int unsigned DWELL_CYCLES = 2500
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [VAL_W-1:0] VAL_I,
  input  logic             VAL_VALID_I,
  output logic [7:0]       LED_O,
  output logic             BUSY_O
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > VAL_W) ? DWELL_CYCLES : VAL_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(VAL_W - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [VAL_W-1:0] work;
  logic [VAL_W-1:0] pend_val;
  logic             pend_flag;
  logic [11:0]      bcd, bcd_adj, bcd_shift;
  logic [3:0]       digit;
  logic [6:0]       seg;
  logic [7:0]       led_next;
  logic             cnt_done, consume;

  assign cnt_done = (cnt == '0);
  assign consume  = (state == BLANK) && cnt_done && pend_flag;

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[10:0], work[VAL_W-1]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  // On the last CONV cycle the digit choice must use the post-shift BCD value.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (VAL_VALID_I) state_next = CONV;
      CONV:    if (cnt_done) state_next = first_show(bcd_shift[11:8], bcd_shift[7:4]);
      SHOW_H:  if (cnt_done) state_next = SHOW_T;
      SHOW_T:  if (cnt_done) state_next = SHOW_O;
      SHOW_O:  if (cnt_done) state_next = BLANK;
      BLANK:   if (cnt_done) state_next = pend_flag ? CONV : first_show(bcd[11:8], bcd[7:4]);
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    digit    = '0;
    led_next = '0;
    BUSY_O   = (state == CONV);
    case (state)
      SHOW_H: begin
        digit    = bcd[11:8];
        led_next = {1'b0, seg};
      end
      SHOW_T: begin
        digit    = bcd[7:4];
        led_next = {1'b0, seg};
      end
      SHOW_O: begin
        digit            = bcd[3:0];
        led_next         = {1'b0, seg};
        led_next[DP_BIT] = 1'b1;
      end
      default: ;
    endcase
  end

  tempsens_seg7_dec u_dec (
    .digit (digit),
    .seg   (seg)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LED_O     <= '0;
      cnt       <= '0;
      work      <= '0;
      bcd       <= '0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
    end else begin
      LED_O <= led_next;

      if (state_next != state)
        cnt <= (state_next == CONV) ? CONV_LOAD : DWELL_LOAD;
      else if (!cnt_done)
        cnt <= cnt - 1'b1;

      if (state == IDLE && VAL_VALID_I) begin
        work <= VAL_I;
        bcd  <= '0;
      end else if (consume) begin
        work <= pend_val;
        bcd  <= '0;
      end else if (state == CONV) begin
        work <= work << 1;
        bcd  <= bcd_shift;
      end

      // A strobe coinciding with consumption re-arms the slot with the new value.
      if (VAL_VALID_I && state != IDLE) begin
        pend_val  <= VAL_I;
        pend_flag <= 1'b1;
      end else if (consume) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tempsens_disp_seq.sv
// Scoreboard bench for tempsens_disp_seq with a 4-cycle dwell.
module tb_tempsens_disp_seq;

  localparam int unsigned VW    = 7;
  localparam int unsigned DWELL = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [VW-1:0] VAL_I = '0;
  logic          VAL_VALID_I = 1'b0;
  logic [7:0]    LED_O;
  logic          BUSY_O;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  typedef struct packed {
    logic [7:0] led;
    logic       conv;
  } item_t;

  item_t      q[$];
  logic [7:0] prev_led;

  tempsens_disp_seq #(
    .VAL_W        (VW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .VAL_I       (VAL_I),
    .VAL_VALID_I (VAL_VALID_I),
    .LED_O       (LED_O),
    .BUSY_O      (BUSY_O)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Expected per-cycle state timeline: LED shows the previous cycle's state.
  task automatic push_conv();
    for (int i = 0; i < int'(VW); i++) q.push_back('{led: 8'h00, conv: 1'b1});
  endtask

  task automatic push_show(input int v);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    if (h != 0)
      for (int i = 0; i < int'(DWELL); i++) q.push_back('{led: seg_of(h), conv: 1'b0});
    if (h != 0 || t != 0)
      for (int i = 0; i < int'(DWELL); i++) q.push_back('{led: seg_of(t), conv: 1'b0});
    for (int i = 0; i < int'(DWELL); i++) q.push_back('{led: seg_of(o) | 8'h80, conv: 1'b0});
    for (int i = 0; i < int'(DWELL); i++) q.push_back('{led: 8'h00, conv: 1'b0});
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RESET = 1'b1;
    VAL_VALID_I = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    q.delete();
  endtask

  task automatic start(input int v);
    @(negedge CLK);
    VAL_I = VW'(v);
    VAL_VALID_I = 1'b1;
    prev_led = 8'h00;
  endtask

  // Advance one cycle, return observed and scoreboard values, optionally strobe.
  task automatic step(input bit do_strobe, input int sval,
                      output logic [7:0] led_obs, output logic [7:0] led_exp,
                      output logic busy_obs, output logic busy_exp);
    item_t it;
    @(negedge CLK);
    VAL_VALID_I = 1'b0;
    led_obs  = LED_O;
    busy_obs = BUSY_O;
    if (q.size() == 0) begin
      led_exp  = 8'hxx;
      busy_exp = 1'bx;
    end else begin
      it       = q.pop_front();
      led_exp  = prev_led;
      busy_exp = it.conv;
      prev_led = it.led;
    end
    if (do_strobe) begin
      VAL_I = VW'(sval);
      VAL_VALID_I = 1'b1;
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if (LED_O !== 8'h00) $display("FAIL reset_led got %h want 00", LED_O); else pass_cnt++;
    chk_cnt++;
    if (BUSY_O !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY_O); else pass_cnt++;
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk_cnt++;
      if (LED_O !== 8'h00) $display("FAIL idle_led k=%0d got %h want 00", k, LED_O); else pass_cnt++;
    end
  endtask

  task automatic test_value(input string name, input int v);
    logic [7:0] lo, le;
    logic       bo, be;
    int         n;
    reset_dut();
    start(v);
    push_conv();
    push_show(v);
    push_show(v);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      step(1'b0, 0, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL %s_led k=%0d got %h want %h", name, k, lo, le); else pass_cnt++;
      chk_cnt++;
      if (bo !== be) $display("FAIL %s_busy k=%0d got %b want %b", name, k, bo, be); else pass_cnt++;
    end
  endtask

  // 40 shown, 73 strobed during SHOW_T: 40 finishes before 73 appears.
  task automatic test_pending();
    logic [7:0] lo, le;
    logic       bo, be;
    int         n;
    reset_dut();
    start(40);
    push_conv(); push_show(40);
    push_conv(); push_show(73); push_show(73);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      step(k == 8, 73, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL pending_led k=%0d got %h want %h", k, lo, le); else pass_cnt++;
      chk_cnt++;
      if (bo !== be) $display("FAIL pending_busy k=%0d got %b want %b", k, bo, be); else pass_cnt++;
    end
  endtask

  task automatic test_last_wins();
    logic [7:0] lo, le;
    logic       bo, be;
    int         n;
    reset_dut();
    start(40);
    push_conv(); push_show(40);
    push_conv(); push_show(74); push_show(74);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      step(k == 8 || k == 16, (k == 8) ? 73 : 74, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL lastwins_led k=%0d got %h want %h", k, lo, le); else pass_cnt++;
      chk_cnt++;
      if (bo !== be) $display("FAIL lastwins_busy k=%0d got %b want %b", k, bo, be); else pass_cnt++;
    end
  endtask

  // 5 shown, 12 pending; 88 strobed on the final BLANK cycle as 12 is consumed.
  task automatic test_back_to_back();
    logic [7:0] lo, le;
    logic       bo, be;
    int         n;
    reset_dut();
    start(5);
    push_conv(); push_show(5);
    push_conv(); push_show(12);
    push_conv(); push_show(88); push_show(88);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      step(k == 8 || k == 14, (k == 8) ? 12 : 88, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL b2b_led k=%0d got %h want %h", k, lo, le); else pass_cnt++;
      chk_cnt++;
      if (bo !== be) $display("FAIL b2b_busy k=%0d got %b want %b", k, bo, be); else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] lo, le;
    logic       bo, be;
    int         n;
    reset_dut();
    start(40);
    push_conv(); push_show(40);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 0, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL prereset_led k=%0d got %h want %h", k, lo, le); else pass_cnt++;
    end
    #2 RESET = 1'b1;
    #1;
    chk_cnt++;
    if (LED_O !== 8'h00) $display("FAIL async_led got %h want 00", LED_O); else pass_cnt++;
    chk_cnt++;
    if (BUSY_O !== 1'b0) $display("FAIL async_busy got %b want 0", BUSY_O); else pass_cnt++;
    @(negedge CLK);
    RESET = 1'b0;
    q.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk_cnt++;
      if (LED_O !== 8'h00) $display("FAIL postreset_led k=%0d got %h want 00", k, LED_O); else pass_cnt++;
      chk_cnt++;
      if (BUSY_O !== 1'b0) $display("FAIL postreset_busy k=%0d got %b want 0", k, BUSY_O); else pass_cnt++;
    end
    start(9);
    push_conv(); push_show(9); push_show(9);
    n = q.size();
    for (int k = 0; k < n; k++) begin
      step(1'b0, 0, lo, le, bo, be);
      chk_cnt++;
      if (lo !== le) $display("FAIL after_reset_led k=%0d got %h want %h", k, lo, le); else pass_cnt++;
      chk_cnt++;
      if (bo !== be) $display("FAIL after_reset_busy k=%0d got %b want %b", k, bo, be); else pass_cnt++;
    end
  endtask

  initial begin
    prev_led = 8'h00;
    test_reset();
    test_value("v127", 127);
    test_value("v5", 5);
    test_value("v100", 100);
    test_value("v0", 0);
    test_pending();
    test_last_wins();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tempsens_disp_seq.md
TEMPSENS_DISP_SEQ -- requirements
Module: tempsens_disp_seq

Interface
REQ-001 SHALL have parameter VAL_W, default 7, the width of the temperature code input (range 0..2^VAL_W-1, max 127).
REQ-002 SHALL have parameter DWELL_CYCLES, default 2500, the number of clock cycles each digit or blank is shown (0.25 s at 10 kHz).
REQ-003 SHALL have port CLK, input, 1, the single system clock.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port VAL_I, input, VAL_W, the unsigned temperature code from the sensor core.
REQ-006 SHALL have port VAL_VALID_I, input, 1, a one-cycle strobe marking VAL_I as a new measurement.
REQ-007 SHALL have port LED_O, output, 8, the 7-segment pattern: bits [6:0] are g,f,e,d,c,b,a and bit 7 is DP, all active-high.
REQ-008 SHALL have port BUSY_O, output, 1, high while the BCD conversion is in progress.

Function
REQ-009 SHALL implement the states IDLE, CONV, SHOW_H, SHOW_T, SHOW_O and BLANK.
REQ-010 In IDLE, LED_O SHALL be 0x00, and a VAL_VALID_I sampled high SHALL load VAL_I into the work register and enter CONV.
REQ-011 CONV SHALL perform a sequential double-dabble, one bit per cycle for exactly VAL_W cycles (add 3 to any BCD nibble >=5, then shift), producing hundreds, tens and ones.
REQ-012 BUSY_O SHALL be high in exactly the VAL_W cycles spent in CONV.
REQ-013 The first digit SHALL appear on LED_O on the (VAL_W+1)th rising edge after the edge that sampled VAL_VALID_I.
REQ-014 After CONV, the state SHALL be SHOW_H if hundreds!=0, else SHOW_T if tens!=0, else SHOW_O (leading-zero suppression).
REQ-015 SHOW_H SHALL be followed by SHOW_T even when tens==0; SHOW_T by SHOW_O; SHOW_O by BLANK.
REQ-016 Each SHOW state and BLANK SHALL last exactly DWELL_CYCLES cycles, timed by a down-counter reloaded on every state entry.
REQ-017 In SHOW states, LED_O[6:0] SHALL be the decoded digit (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F); DP SHALL be set only in SHOW_O (end-of-number marker).
REQ-018 In BLANK, LED_O SHALL be 0x00.
REQ-019 At the end of BLANK, the block SHALL enter CONV if a pending value exists; otherwise it SHALL re-enter the first SHOW state of the current value, so display loops indefinitely.
REQ-020 A VAL_VALID_I outside IDLE SHALL store VAL_I into a pending register and set a pending flag; a later strobe SHALL overwrite it (last value wins).
REQ-021 Entering CONV SHALL consume and clear the pending flag.
REQ-022 A strobe in the same cycle the pending value is consumed SHALL set the flag again with the new value, and no value SHALL be lost.
REQ-023 The in-progress digit sequence SHALL never be altered mid-number by a new value.
REQ-024 Any BCD digit >9 is unreachable; the decoder SHALL output 0x00 for codes 10..15.

Reset
REQ-025 RESET high SHALL asynchronously force state IDLE, LED_O=0x00, BUSY_O=0, pending flag=0, and the dwell counter, work and BCD registers to 0.
REQ-026 Reset asserted mid-CONV or mid-SHOW SHALL discard all stored values, and the first post-reset strobe SHALL be handled as from IDLE.

Structure
REQ-027 The state enum and the segment constants (digits 0..9, blank, DP bit index) SHALL reside in shared package tempsens_pkg.
REQ-028 Digit-to-segment decoding SHALL be the combinational sub-module tempsens_seg7_dec (4-bit in, 7-bit out), reusable by the debug display path.
REQ-029 LED_O SHALL be registered with no combinational path from the inputs.

Verification (DWELL_CYCLES=4 in all scenarios)
REQ-030 Strobe VAL_I=127 -> BUSY_O high 7 cycles; LED_O = 0x06, 0x5B, 0x87, 0x00, 4 cycles each, then repeats.
REQ-031 Strobe VAL_I=5 -> LED_O = 0xED for 4 cycles, then 0x00 for 4, repeating (no leading zeros).
REQ-032 Strobe VAL_I=100 -> LED_O = 0x06, 0x3F, 0xBF, 0x00 (interior zero shown).
REQ-033 Show 40, then strobe 73 during SHOW_T -> 0x66, 0xBF, 0x00 complete first, then CONV and 0x07, 0xCF; a second strobe of 74 before BLANK ends -> 74 is shown and 73 never is.
REQ-034 Assert RESET mid-SHOW_T -> LED_O=0x00 and BUSY_O=0 immediately (asynchronous); with no strobe the output stays 0x00; a strobe of 9 -> 0xEF.
REQ-035 Strobe in the final BLANK cycle, simultaneous with consumption of a pending 12 -> 12 is displayed next, followed by the new value.
